// File: rtl/stream_ctrl_if.sv
// stream_ctrl_if: FT245 RX byte handshake plus sample-FIFO write/status bus
// for stream_ctrl.
//   rx_data_si / rx_valid_si / rx_ready_si : host byte stream (valid/ready)
//   fifo_wr_data / fifo_wr_en               : FIFO write port
//   fifo_full / fifo_empty                  : FIFO status
//   read_sample                             : modulator read strobe (monitored)
// slave  = stream_ctrl side, master = wrapper/FIFO/modulator side.
interface stream_ctrl_if;
  logic [7:0] rx_data_si;
  logic       rx_valid_si;
  logic       rx_ready_si;
  logic [7:0] fifo_wr_data;
  logic       fifo_wr_en;
  logic       fifo_full;
  logic       fifo_empty;
  logic       read_sample;

  modport master (
    output rx_data_si, rx_valid_si, fifo_full, fifo_empty, read_sample,
    input  rx_ready_si, fifo_wr_data, fifo_wr_en
  );

  modport slave (
    input  rx_data_si, rx_valid_si, fifo_full, fifo_empty, read_sample,
    output rx_ready_si, fifo_wr_data, fifo_wr_en
  );
endinterface

// File: rtl/stream_ctrl.sv
// stream_ctrl: parses the framed host byte stream (SYNC, CMD, LEN, payload),
// routes DATA payload into the sample FIFO, tracks FIFO occupancy and gates
// the modulator enable (prefill threshold, underrun, host STOP drain).
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : RX handshake, FIFO write port and status, read_sample
//   mod_enable      : modulator enable (registered)
//   underrun        : one-cycle underrun pulse (registered)
//   running         : high in RUN or DRAIN (registered)
//   frame_count     : frames accepted, 16-bit wrapping
//   underrun_count  : underruns seen, 16-bit wrapping
// Build option: define STREAM_CTRL_STATS_EN to implement the two counters;
// otherwise they read as zero.
module stream_ctrl #(
  parameter int unsigned DEPTH_WIDTH = 8,
  parameter int unsigned PREFILL     = 128,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  stream_ctrl_if.slave      bus,
  output logic              mod_enable,
  output logic              underrun,
  output logic              running,
  output logic [15:0]       frame_count,
  output logic [15:0]       underrun_count
);

  localparam logic [7:0] CMD_DATA = 8'h01;
  localparam logic [7:0] CMD_STOP = 8'h02;
  localparam logic [DEPTH_WIDTH:0] LEVEL_MAX = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] PREFILL_L = PREFILL[DEPTH_WIDTH:0];

  typedef enum logic [2:0] {P_HUNT, P_CMD, P_LEN, P_DATA, P_DROP} pstate_t;
  typedef enum logic [1:0] {G_IDLE, G_PREFILL, G_RUN, G_DRAIN} gstate_t;

  pstate_t pstate, pstate_nxt;
  gstate_t gstate, gstate_nxt;
  logic [7:0]           cmd_q, cmd_nxt;
  logic [8:0]           remaining, remaining_nxt;
  logic [DEPTH_WIDTH:0] level, level_nxt;
  logic accept, frame_last, drain_req, rd_take, underrun_evt;

  // Parser: handshake, FIFO write strobe and next-state
  always_comb begin
    bus.rx_ready_si  = rst | (pstate != P_DATA) | !bus.fifo_full;
    accept           = bus.rx_valid_si & bus.rx_ready_si;
    bus.fifo_wr_en   = accept & (pstate == P_DATA) & !rst;
    bus.fifo_wr_data = bus.rx_data_si;
    frame_last       = accept & ((pstate == P_DATA) | (pstate == P_DROP))
                       & (remaining == 9'd1);
    drain_req        = frame_last & (pstate == P_DROP) & (cmd_q == CMD_STOP);
    pstate_nxt       = pstate;
    cmd_nxt          = cmd_q;
    remaining_nxt    = remaining;
    if (accept) begin
      case (pstate)
        P_HUNT: if (bus.rx_data_si == SYNC_BYTE) pstate_nxt = P_CMD;
        P_CMD: begin
          cmd_nxt    = bus.rx_data_si;
          pstate_nxt = P_LEN;
        end
        P_LEN: begin
          remaining_nxt = (bus.rx_data_si == 8'd0) ? 9'd256 : {1'b0, bus.rx_data_si};
          pstate_nxt    = (cmd_q == CMD_DATA) ? P_DATA : P_DROP;
        end
        P_DATA, P_DROP: begin
          remaining_nxt = remaining - 9'd1;
          if (remaining == 9'd1) pstate_nxt = P_HUNT;
        end
        default: pstate_nxt = P_HUNT;
      endcase
    end
  end

  // Occupancy: saturating at both ends, simultaneous write+read cancels
  always_comb begin
    rd_take   = bus.read_sample & !bus.fifo_empty;
    level_nxt = level;
    if (bus.fifo_wr_en && !rd_take && level != LEVEL_MAX)
      level_nxt = level + 1'b1;
    else if (rd_take && !bus.fifo_wr_en && level != '0)
      level_nxt = level - 1'b1;
  end

  // Gating: the enable threshold looks at next-cycle occupancy so the
  // enable rises right after the threshold write; the empty checks use the
  // registered level so the enable falls one cycle after level hits zero.
  always_comb begin
    gstate_nxt   = gstate;
    underrun_evt = 1'b0;
    case (gstate)
      G_IDLE:
        if (bus.fifo_wr_en) gstate_nxt = (level_nxt >= PREFILL_L) ? G_RUN : G_PREFILL;
      G_PREFILL:
        if (drain_req)                    gstate_nxt = (level != '0) ? G_DRAIN : G_IDLE;
        else if (level_nxt >= PREFILL_L)  gstate_nxt = G_RUN;
      G_RUN:
        if (drain_req) gstate_nxt = G_DRAIN;
        else if (level == '0 && !bus.fifo_wr_en) begin
          underrun_evt = 1'b1;
          gstate_nxt   = G_PREFILL;
        end
      G_DRAIN:
        if (level == '0) gstate_nxt = G_IDLE;
      default: gstate_nxt = G_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pstate     <= P_HUNT;
      gstate     <= G_IDLE;
      cmd_q      <= '0;
      remaining  <= '0;
      level      <= '0;
      mod_enable <= 1'b0;
      running    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      pstate     <= pstate_nxt;
      gstate     <= gstate_nxt;
      cmd_q      <= cmd_nxt;
      remaining  <= remaining_nxt;
      level      <= level_nxt;
      mod_enable <= (gstate_nxt == G_RUN) || (gstate_nxt == G_DRAIN);
      running    <= (gstate_nxt == G_RUN) || (gstate_nxt == G_DRAIN);
      underrun   <= underrun_evt;
    end
  end

`ifdef STREAM_CTRL_STATS_EN
  logic [15:0] frame_cnt_q, underrun_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else begin
      if (frame_last)   frame_cnt_q    <= frame_cnt_q + 16'd1;
      if (underrun_evt) underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign frame_count    = frame_cnt_q;
  assign underrun_count = underrun_cnt_q;
`else
  assign frame_count    = '0;
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_stream_ctrl.sv
// tb_stream_ctrl: directed frames into stream_ctrl (PREFILL=4) with a
// behavioural occupancy/enable model checked every cycle, plus literal
// expectations for written bytes, enable edges and counters.
module tb_stream_ctrl;
  localparam int unsigned DW = 8;
  localparam int unsigned PF = 4;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_ctrl_if bus();
  logic        mod_enable, underrun, running;
  logic [15:0] frame_count, underrun_count;

  stream_ctrl #(.DEPTH_WIDTH(DW), .PREFILL(PF), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mod_enable(mod_enable), .underrun(underrun), .running(running),
    .frame_count(frame_count), .underrun_count(underrun_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bench-side FIFO occupancy drives fifo_empty
  int fifo_cnt = 0;
  always @(posedge clk) begin
    if (rst) fifo_cnt <= 0;
    else fifo_cnt <= fifo_cnt + (bus.fifo_wr_en ? 1 : 0)
                     - ((bus.read_sample && fifo_cnt > 0) ? 1 : 0);
  end
  assign bus.fifo_empty = (fifo_cnt == 0);

  // Stimulus annotations set by the driver
  bit a_data_phase = 0;   // parser is inside a DATA payload
  bit a_last       = 0;   // byte on the bus is the last of its frame
  bit a_stop_last  = 0;   // ... and the frame is a STOP

  // Model state
  int  m_lvl = 0, m_frames = 0, m_uns = 0, un_pulses = 0;
  bit  m_en = 0, m_primed = 0, m_drain = 0, m_un = 0, started = 0;
  logic [7:0] wlog[$];

  always @(negedge clk) begin
    bit exp_rdy, acc, w, rd, drn;
    int nl;
    if (started) begin
      chk("mod_enable", mod_enable, m_en);
      chk("running", running, m_en);
      chk("underrun", underrun, m_un);
`ifdef STREAM_CTRL_STATS_EN
      chk("frame_count", frame_count, 32'(m_frames[15:0]));
      chk("underrun_count", underrun_count, 32'(m_uns[15:0]));
`else
      chk("frame_count", frame_count, 0);
      chk("underrun_count", underrun_count, 0);
`endif
    end
    exp_rdy = rst || !(a_data_phase && bus.fifo_full);
    chk("rx_ready", bus.rx_ready_si, exp_rdy);
    acc = bus.rx_valid_si && exp_rdy;
    w   = acc && a_data_phase && !rst;
    chk("wr_en", bus.fifo_wr_en, w);
    if (w) begin
      chk("wr_data", bus.fifo_wr_data, bus.rx_data_si);
      wlog.push_back(bus.fifo_wr_data);
    end
    if (underrun === 1'b1) un_pulses++;
    rd  = bus.read_sample && !bus.fifo_empty;
    drn = acc && a_stop_last && !rst;
    if (rst) begin
      m_lvl = 0; m_frames = 0; m_uns = 0;
      m_en = 0; m_primed = 0; m_drain = 0; m_un = 0;
      started = 1;
    end else begin
      nl = m_lvl + (w ? 1 : 0) - (rd ? 1 : 0);
      if (nl < 0) nl = 0;
      if (nl > (1 << DW)) nl = 1 << DW;
      m_un = 0;
      if (acc && a_last) m_frames++;
      if (!m_en) begin
        if (drn && m_primed) begin
          if (m_lvl > 0) begin m_en = 1; m_drain = 1; end
          else m_primed = 0;
        end else begin
          if ((m_primed || w) && nl >= PF) m_en = 1;
          if (w) m_primed = 1;
        end
      end else if (m_drain) begin
        if (m_lvl == 0) begin m_en = 0; m_drain = 0; m_primed = 0; end
      end else if (drn) begin
        m_drain = 1;
      end else if (m_lvl == 0 && !w) begin
        m_en = 0; m_un = 1; m_uns++;
      end
      m_lvl = nl;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, input bit stop_last);
    bit ok = 0;
    bus.rx_data_si  = b;
    bus.rx_valid_si = 1'b1;
    a_last          = last;
    a_stop_last     = stop_last;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = (bus.rx_ready_si === 1'b1);
      step();
    end
    if (!ok) chk("accept_timeout", 0, 1);
    bus.rx_valid_si = 1'b0;
    a_last          = 0;
    a_stop_last     = 0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                            input bq_t p, input int stall_at);
    int n;
    n = (len == 8'd0) ? 256 : int'(len);
    send_byte(8'hA5, 0, 0);
    send_byte(cmd, 0, 0);
    send_byte(len, 0, 0);
    if (cmd == 8'h01) a_data_phase = 1;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        bus.rx_data_si  = p[i];
        bus.rx_valid_si = 1'b1;
        bus.fifo_full   = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("stall_ready", bus.rx_ready_si, 0);
          chk("stall_wr_en", bus.fifo_wr_en, 0);
          step();
        end
        bus.fifo_full = 1'b0;
      end
      send_byte(p[i], i == n - 1, (cmd == 8'h02) && (i == n - 1));
    end
    a_data_phase = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t p;
    int n0;
    bus.rx_data_si  = 8'h00;
    bus.rx_valid_si = 1'b0;
    bus.fifo_full   = 1'b0;
    bus.read_sample = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mod_enable", mod_enable, 0);
    chk("rst_running", running, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_frame_count", frame_count, 0);

    // Leading junk dropped, one 4-byte DATA frame
    send_byte(8'h00, 0, 0);
    send_byte(8'h11, 0, 0);
    p = '{8'h10, 8'h20, 8'h30, 8'h40};
    send_frame(8'h01, 8'd4, p, -1);
    chk("t1_nwrites", wlog.size(), 4);
    chk("t1_w0", wlog[0], 8'h10);
    chk("t1_w1", wlog[1], 8'h20);
    chk("t1_w2", wlog[2], 8'h30);
    chk("t1_w3", wlog[3], 8'h40);
    chk("t1_enable", mod_enable, 1);
`ifdef STREAM_CTRL_STATS_EN
    chk("t1_frames", frame_count, 1);
`endif

    // Modulator drains the 4 bytes, then underruns once
    bus.read_sample = 1'b1;
    repeat (8) step();
    bus.read_sample = 1'b0;
    chk("t2_pulses", un_pulses, 1);
    chk("t2_enable", mod_enable, 0);
`ifdef STREAM_CTRL_STATS_EN
    chk("t2_uruns", underrun_count, 1);
`endif

    // Full stall mid-payload, no loss or duplication
    n0 = wlog.size();
    p = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_frame(8'h01, 8'd6, p, 2);
    chk("t3_nwrites", wlog.size(), n0 + 6);
    for (int i = 0; i < 6; i++) chk("t3_data", wlog[n0 + i], i + 1);
    chk("t3_enable", mod_enable, 1);

    // Level 10 in RUN, then STOP drains without underrun
    p = '{8'h07, 8'h08, 8'h09, 8'h0A};
    send_frame(8'h01, 8'd4, p, -1);
    n0 = wlog.size();
    p = '{8'hFF};
    send_frame(8'h02, 8'd1, p, -1);
    chk("t4_no_write", wlog.size(), n0);
    chk("t4_enable", mod_enable, 1);
    bus.read_sample = 1'b1;
    repeat (10) step();
    chk("t4_enable_10", mod_enable, 1);
    step();
    chk("t4_enable_11", mod_enable, 0);
    repeat (3) step();
    bus.read_sample = 1'b0;
    chk("t4_pulses", un_pulses, 1);

    // 256-byte dropped frame, then a single DATA byte
    p = {};
    for (int i = 0; i < 256; i++) p.push_back(8'(i));
    n0 = wlog.size();
    send_frame(8'h07, 8'd0, p, -1);
    chk("t5_dropped", wlog.size(), n0);
    p = '{8'h55};
    send_frame(8'h01, 8'd1, p, -1);
    chk("t5_nwrites", wlog.size(), n0 + 1);
    chk("t5_last", wlog[wlog.size() - 1], 8'h55);
`ifdef STREAM_CTRL_STATS_EN
    chk("t5_frames", frame_count, 6);
`endif

    // Reset in the middle of a DATA payload
    send_byte(8'hA5, 0, 0);
    send_byte(8'h01, 0, 0);
    send_byte(8'h08, 0, 0);
    a_data_phase = 1;
    send_byte(8'h21, 0, 0);
    send_byte(8'h22, 0, 0);
    rst = 1'b1;
    a_data_phase = 0;
    bus.rx_data_si  = 8'h23;
    bus.rx_valid_si = 1'b1;
    @(negedge clk);
    chk("t6_rst_ready", bus.rx_ready_si, 1);
    chk("t6_rst_wr_en", bus.fifo_wr_en, 0);
    step();
    @(negedge clk);
    chk("t6_rst_enable", mod_enable, 0);
    chk("t6_rst_running", running, 0);
    chk("t6_rst_underrun", underrun, 0);
    chk("t6_rst_frames", frame_count, 0);
    chk("t6_rst_uruns", underrun_count, 0);
    step();
    rst = 1'b0;
    bus.rx_valid_si = 1'b0;
    n0 = wlog.size();
    p = '{8'h77};
    send_frame(8'h01, 8'd1, p, -1);
    chk("t6_nwrites", wlog.size(), n0 + 1);
    chk("t6_last", wlog[wlog.size() - 1], 8'h77);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
